// File: rtl/spm_config_arbiter.sv
// Round-robin arbiter that serialises writes onto the shared SPM config register bus.
// Offset writes additionally wait for the slewed X0/Y0/Z0 monitors to reach their targets.
module spm_config_arbiter #(
   parameter int          NREQ           = 4,
   parameter int          CFG_WIDTH      = 512,
   parameter int          HOLD_CYCLES    = 4,
   parameter int          GAP_CYCLES     = 2,
   parameter logic [31:0] IDLE_ADDR      = 32'd0,
   parameter logic [31:0] SETTLE_ADDR    = 32'd1100,
   parameter int          TIMEOUT_CYCLES = 125000000
) (
   input  logic                      a_clk,
   input  logic                      a_rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*32-1:0]        req_addr,
   input  logic [NREQ*CFG_WIDTH-1:0] req_data,
   output logic [NREQ-1:0]           req_ready,
   output logic [NREQ-1:0]           req_done,
   output logic [31:0]               config_addr,
   output logic [CFG_WIDTH-1:0]      config_data,
   input  logic [31:0]               S_AXIS_X0MON_tdata,
   input  logic [31:0]               S_AXIS_Y0MON_tdata,
   input  logic [31:0]               S_AXIS_Z0MON_tdata,
   output logic                      busy,
   output logic [2:0]                grant_id,
   output logic                      settle_timeout
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, HOLD, SETTLE, GAP} state_t;

   state_t               state;
   state_t               state_next;
   logic [7:0]           cnt;
   logic [7:0]           cnt_next;
   logic [31:0]          settle_cnt;
   logic [31:0]          settle_cnt_next;
   logic [IW-1:0]        gid;
   logic [IW-1:0]        cand;
   logic [IW-1:0]        sel_idx;
   logic                 sel_valid;
   logic [31:0]          sel_addr;
   logic [CFG_WIDTH-1:0] sel_data;
   logic [31:0]          lat_addr;
   logic [31:0]          hold_addr;
   logic [31:0]          mon_x;
   logic [31:0]          mon_y;
   logic [31:0]          mon_z;
   logic                 mon_match;
   logic                 accept;
   logic                 timeout_hit;

   // Walk backwards so the requester closest after the last grant wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = gid;
      cand      = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IW'((int'(gid) + k) % NREQ);
         if (req_valid[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel_idx == IW'(i)) begin
            sel_addr = req_addr[32*i +: 32];
            sel_data = req_data[CFG_WIDTH*i +: CFG_WIDTH];
         end
      end
   end

   assign accept = (state == IDLE) && sel_valid && !a_rst;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = accept && (sel_idx == IW'(i));
      end
   end

   // config_data still holds the latched write while settling, so it doubles as the target.
   assign mon_match = (mon_x == config_data[31:0]) &&
                      (mon_y == config_data[63:32]) &&
                      (mon_z == config_data[95:64]);

   assign hold_addr = (state == IDLE) ? sel_addr : lat_addr;
   assign busy      = (state != IDLE);
   assign grant_id  = 3'(gid);

   always_comb begin
      state_next      = state;
      cnt_next        = cnt;
      settle_cnt_next = settle_cnt;
      timeout_hit     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (sel_addr == IDLE_ADDR) begin
                  state_next = GAP;
                  cnt_next   = 8'(GAP_CYCLES - 1);
               end else begin
                  state_next = HOLD;
                  cnt_next   = 8'(HOLD_CYCLES - 1);
               end
            end
         end
         HOLD: begin
            if (cnt == 8'd0) begin
               if (lat_addr == SETTLE_ADDR) begin
                  state_next      = SETTLE;
                  settle_cnt_next = '0;
               end else begin
                  state_next = GAP;
                  cnt_next   = 8'(GAP_CYCLES - 1);
               end
            end else begin
               cnt_next = cnt - 8'd1;
            end
         end
         SETTLE: begin
            if (mon_match) begin
               state_next = GAP;
               cnt_next   = 8'(GAP_CYCLES - 1);
            end else if (settle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_next  = GAP;
               cnt_next    = 8'(GAP_CYCLES - 1);
            end else begin
               settle_cnt_next = settle_cnt + 32'd1;
            end
         end
         GAP: begin
            if (cnt == 8'd0) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt - 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A no-op request leaves config_data untouched since nothing is written to the bus.
   always_ff @(posedge a_clk) begin
      if (a_rst) begin
         state          <= IDLE;
         cnt            <= '0;
         settle_cnt     <= '0;
         gid            <= IW'(NREQ - 1);
         lat_addr       <= IDLE_ADDR;
         config_addr    <= IDLE_ADDR;
         config_data    <= '0;
         req_done       <= '0;
         settle_timeout <= 1'b0;
         mon_x          <= '0;
         mon_y          <= '0;
         mon_z          <= '0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         settle_cnt <= settle_cnt_next;
         mon_x      <= S_AXIS_X0MON_tdata;
         mon_y      <= S_AXIS_Y0MON_tdata;
         mon_z      <= S_AXIS_Z0MON_tdata;
         if (accept) begin
            gid      <= sel_idx;
            lat_addr <= sel_addr;
            if (sel_addr != IDLE_ADDR) begin
               config_data <= sel_data;
            end
         end
         if (accept && (sel_addr == SETTLE_ADDR)) begin
            settle_timeout <= 1'b0;
         end else if (timeout_hit) begin
            settle_timeout <= 1'b1;
         end
         config_addr <= (state_next == HOLD) ? hold_addr : IDLE_ADDR;
         for (int i = 0; i < NREQ; i++) begin
            req_done[i] <= (state == GAP) && (state_next == IDLE) && (gid == IW'(i));
         end
      end
   end

endmodule

// File: tb/tb_spm_config_arbiter.sv
// Directed and randomized checks of spm_config_arbiter against a transaction-timing model
// that predicts bus, ready, done and timeout behaviour from each accept time.
module tb_spm_config_arbiter;

   localparam int NREQ = 4;
   localparam int CFGW = 512;
   localparam int HOLD = 4;
   localparam int GAP  = 2;
   localparam int TMO  = 50;

   logic                 a_clk;
   logic                 a_rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*32-1:0]   req_addr;
   logic [NREQ*CFGW-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_done;
   logic [31:0]          config_addr;
   logic [CFGW-1:0]      config_data;
   logic [31:0]          mon_x;
   logic [31:0]          mon_y;
   logic [31:0]          mon_z;
   logic                 busy;
   logic [2:0]           grant_id;
   logic                 settle_timeout;

   spm_config_arbiter #(
      .NREQ(NREQ), .CFG_WIDTH(CFGW), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
      .IDLE_ADDR(32'd0), .SETTLE_ADDR(32'd1100), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .a_clk(a_clk), .a_rst(a_rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .req_done(req_done),
      .config_addr(config_addr), .config_data(config_data),
      .S_AXIS_X0MON_tdata(mon_x), .S_AXIS_Y0MON_tdata(mon_y), .S_AXIS_Z0MON_tdata(mon_z),
      .busy(busy), .grant_id(grant_id), .settle_timeout(settle_timeout)
   );

   initial a_clk = 1'b0;
   always #5 a_clk = ~a_clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Model of the in-flight transaction, expressed as scheduled cycle numbers.
   bit              m_act;
   int              m_tacc;
   int              m_tdone;
   int              m_tset;
   int              m_gid;
   logic [31:0]     m_addr;
   bit              m_noop;
   bit              m_settle;
   bit              m_to;
   logic [CFGW-1:0] m_data;
   logic [31:0]     prev_x, prev_y, prev_z;

   bit              auto_drop;
   logic [NREQ-1:0] drop_mask;
   logic [NREQ-1:0] ready_seen;
   logic [NREQ-1:0] done_seen;
   int              last_ready_cyc;
   int              last_done_cyc;
   int              grant_log[$];

   task automatic checkOutput(input string tag, input logic [CFGW-1:0] obs, input logic [CFGW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int rrPick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [CFGW-1:0] randData();
      logic [CFGW-1:0] d;
      for (int k = 0; k < CFGW / 32; k++) d[32*k +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [31:0] randAddr();
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 5);
      if (kind == 0) return 32'd0;
      if (kind == 1) return 32'd1100;
      a = 32'($urandom_range(1, 4095));
      if (a == 32'd1100) a = 32'd1101;
      return a;
   endfunction

   task automatic setReq(input int i, input logic [31:0] a, input logic [CFGW-1:0] d);
      req_addr[32*i +: 32]     = a;
      req_data[CFGW*i +: CFGW] = d;
   endtask

   task automatic modelReset();
      m_act   = 1'b0;
      m_gid   = NREQ - 1;
      m_data  = '0;
      m_to    = 1'b0;
      m_tdone = -1;
      m_noop  = 1'b0;
   endtask

   // One clock cycle: check every output against the model, then advance the model.
   task automatic applyStimulus();
      logic [NREQ-1:0] e_ready, e_done;
      logic [31:0]     e_addr, pa;
      logic [CFGW-1:0] pd;
      bit              idle_now;
      int              pick;
      #1;
      idle_now = !m_act || (cyc == m_tdone);
      pick     = (idle_now && !a_rst) ? rrPick(req_valid, m_gid) : -1;
      e_ready  = '0;
      if (pick >= 0) e_ready[pick] = 1'b1;
      e_done = '0;
      if (m_act && cyc == m_tdone) e_done[m_gid] = 1'b1;
      e_addr = (m_act && !m_noop && cyc > m_tacc && cyc <= m_tacc + HOLD) ? m_addr : 32'd0;
      checkOutput("busy", busy, !idle_now);
      checkOutput("req_ready", req_ready, e_ready);
      checkOutput("req_done", req_done, e_done);
      checkOutput("config_addr", config_addr, e_addr);
      checkOutput("config_data", config_data, m_data);
      checkOutput("grant_id", grant_id, 3'(m_gid));
      checkOutput("settle_timeout", settle_timeout, m_to);
      ready_seen |= req_ready;
      done_seen  |= req_done;
      if (req_ready != '0) last_ready_cyc = cyc;
      if (req_done != '0) last_done_cyc = cyc;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
      drop_mask = '0;
      if (a_rst) begin
         modelReset();
      end else begin
         if (m_act && cyc == m_tdone) m_act = 1'b0;
         if (m_act && m_settle && m_tdone < 0 && cyc >= m_tset) begin
            if ({prev_z, prev_y, prev_x} == m_data[95:0]) begin
               m_tdone = cyc + GAP + 1;
            end else if (cyc == m_tset + TMO - 1) begin
               m_to    = 1'b1;
               m_tdone = cyc + GAP + 1;
            end
         end
         if (pick >= 0) begin
            pa       = req_addr[32*pick +: 32];
            pd       = req_data[CFGW*pick +: CFGW];
            m_act    = 1'b1;
            m_tacc   = cyc;
            m_gid    = pick;
            m_addr   = pa;
            m_noop   = (pa == 32'd0);
            m_settle = (pa == 32'd1100);
            if (!m_noop) m_data = pd;
            if (m_settle) m_to = 1'b0;
            m_tset  = cyc + HOLD + 1;
            m_tdone = m_noop ? cyc + GAP + 1 : (m_settle ? -1 : cyc + HOLD + GAP + 1);
            drop_mask[pick] = 1'b1;
         end
      end
      prev_x = mon_x;
      prev_y = mon_y;
      prev_z = mon_z;
      cyc++;
      @(posedge a_clk);
      #1;
      if (auto_drop) req_valid = req_valid & ~drop_mask;
   endtask

   task automatic drain(input int budget);
      req_valid = '0;
      for (int n = 0; n < budget && m_act; n++) applyStimulus();
      checkOutput("drain_busy", busy, 1'b0);
   endtask

   task automatic clearObs();
      ready_seen     = '0;
      done_seen      = '0;
      last_ready_cyc = -1000;
      last_done_cyc  = -2000;
   endtask

   initial begin
      logic [CFGW-1:0] d;
      int              s_cyc;
      int              exp_rr[5];
      exp_rr = '{0, 1, 2, 3, 0};

      a_rst = 1'b1;
      req_valid = '0;
      req_addr = '0;
      req_data = '0;
      mon_x = '0; mon_y = '0; mon_z = '0;
      prev_x = '0; prev_y = '0; prev_z = '0;
      auto_drop = 1'b1;
      clearObs();
      repeat (2) @(posedge a_clk);
      #1;
      modelReset();
      applyStimulus();
      a_rst = 1'b0;

      // Round-robin with all four requesters held valid.
      $display("[TB] round-robin");
      auto_drop = 1'b0;
      for (int i = 0; i < NREQ; i++) setReq(i, 32'(3000 + i), randData());
      req_valid = '1;
      grant_log.delete();
      for (int n = 0; n < 60 && grant_log.size() < 5; n++) applyStimulus();
      for (int i = 0; i < 5; i++)
         checkOutput("rr_order", (grant_log.size() > i) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp_rr[i]));
      auto_drop = 1'b1;
      drain(40);

      // Single write from requester 1.
      $display("[TB] single write");
      clearObs();
      d = randData();
      d[63:0] = {32'h1000_0000, 32'h0};
      setReq(1, 32'd1101, d);
      req_valid[1] = 1'b1;
      for (int n = 0; n < 30 && !done_seen[1]; n++) applyStimulus();
      checkOutput("single_latency", 32'(last_done_cyc - last_ready_cyc), 32'(HOLD + GAP + 1));
      drain(20);

      // Settle success: X ramps 32 per cycle up to 1000, Y/Z already on target.
      $display("[TB] settle success");
      clearObs();
      d = randData();
      d[31:0] = 32'd1000;
      mon_x = 32'd0;
      mon_y = d[63:32];
      mon_z = d[95:64];
      setReq(2, 32'd1100, d);
      req_valid[2] = 1'b1;
      s_cyc = -100;
      for (int n = 0; n < 80 && !done_seen[2]; n++) begin
         mon_x = (mon_x + 32'd32 >= 32'd1000) ? 32'd1000 : mon_x + 32'd32;
         if (mon_x == 32'd1000 && s_cyc < 0) s_cyc = cyc;
         applyStimulus();
      end
      checkOutput("settle_latency", 32'(last_done_cyc - s_cyc), 32'(GAP + 2));
      checkOutput("settle_no_timeout", settle_timeout, 1'b0);
      drain(20);

      // Settle timeout: X never matches.
      $display("[TB] settle timeout");
      clearObs();
      d = randData();
      mon_x = d[31:0] ^ 32'd1;
      mon_y = d[63:32];
      mon_z = d[95:64];
      setReq(3, 32'd1100, d);
      req_valid[3] = 1'b1;
      for (int n = 0; n < 100 && !done_seen[3]; n++) applyStimulus();
      checkOutput("timeout_latency", 32'(last_done_cyc - last_ready_cyc), 32'(HOLD + TMO + GAP + 1));
      checkOutput("timeout_flag", settle_timeout, 1'b1);
      clearObs();
      d = randData();
      d[95:0] = {mon_z, mon_y, mon_x};
      setReq(0, 32'd1100, d);
      req_valid[0] = 1'b1;
      for (int n = 0; n < 10 && !ready_seen[0]; n++) applyStimulus();
      checkOutput("timeout_clear", settle_timeout, 1'b0);
      drain(40);

      // No-op request skips the bus write.
      $display("[TB] no-op");
      clearObs();
      setReq(1, 32'd0, randData());
      req_valid[1] = 1'b1;
      for (int n = 0; n < 20 && !done_seen[1]; n++) applyStimulus();
      checkOutput("noop_latency", 32'(last_done_cyc - last_ready_cyc), 32'(GAP + 1));
      drain(20);

      // Cancel: requester 2 withdraws while requester 0 is in flight.
      $display("[TB] cancel");
      clearObs();
      setReq(0, 32'd4000, randData());
      req_valid[0] = 1'b1;
      for (int n = 0; n < 10 && !ready_seen[0]; n++) applyStimulus();
      setReq(2, 32'd4100, randData());
      req_valid[2] = 1'b1;
      applyStimulus();
      applyStimulus();
      req_valid[2] = 1'b0;
      drain(20);
      for (int n = 0; n < 4; n++) applyStimulus();
      checkOutput("cancel_never_granted", ready_seen[2], 1'b0);

      // Reset two cycles after acceptance.
      $display("[TB] reset mid-hold");
      clearObs();
      setReq(2, 32'd5000, randData());
      req_valid[2] = 1'b1;
      for (int n = 0; n < 10 && !ready_seen[2]; n++) applyStimulus();
      applyStimulus();
      a_rst = 1'b1;
      applyStimulus();
      a_rst = 1'b0;
      checkOutput("rst_addr", config_addr, 32'd0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_grant", grant_id, 3'(NREQ - 1));
      for (int n = 0; n < 10; n++) applyStimulus();
      checkOutput("rst_no_done", done_seen, '0);

      // Randomized traffic with cancels, no-ops and settle writes.
      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
               setReq(i, randAddr(), randData());
               req_valid[i] = 1'b1;
            end else if (req_valid[i] && $urandom_range(0, 31) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         if (m_act && m_settle && $urandom_range(0, 3) == 0) begin
            {mon_z, mon_y, mon_x} = m_data[95:0];
         end else begin
            mon_x = $urandom; mon_y = $urandom; mon_z = $urandom;
         end
         applyStimulus();
      end
      mon_x = m_data[31:0]; mon_y = m_data[63:32]; mon_z = m_data[95:64];
      drain(80);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spm_config_arbiter.md
Name: spm_config_arbiter

Overview:
- Shares the single config_addr/config_data register bus of the SPM control/offset datapath among NREQ requesters (host PS bridge, GVP, auto-approach, scan supervisor).
- Requests are granted round-robin and serialised. Each write is held on the bus for a fixed number of cycles, then the bus returns to an idle address.
- For offset writes, the block also waits until the slew-limited X0/Y0/Z0 monitor outputs reach the commanded targets before signalling completion.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CFG_WIDTH, 512, config_data width.
- HOLD_CYCLES, 4, cycles a granted address/data is driven (>=1).
- GAP_CYCLES, 2, idle-address cycles after each write (>=1).
- IDLE_ADDR, 0, address driven when no write is active; matches no register.
- SETTLE_ADDR, 1100, address that triggers offset settle-wait.
- TIMEOUT_CYCLES, 125000000, maximum settle wait (1 s at 125 MHz).

Ports:
- a_clk  in  1  clock.
- a_rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_addr  in  NREQ*32  flattened; requester i uses [32*i+31:32*i].
- req_data  in  NREQ*CFG_WIDTH  flattened, same ordering.
- req_ready  out  NREQ  one-hot acceptance, high for one cycle.
- req_done  out  NREQ  one-hot completion pulse.
- config_addr  out  32  to datapath.
- config_data  out  CFG_WIDTH  to datapath.
- S_AXIS_X0MON_tdata  in  32  current X offset.
- S_AXIS_Y0MON_tdata  in  32  current Y offset.
- S_AXIS_Z0MON_tdata  in  32  current Z offset.
- busy  out  1  state != IDLE.
- grant_id  out  3  index of the last granted requester.
- settle_timeout  out  1  sticky; set on timeout, cleared by reset or by the next accepted SETTLE_ADDR write.

Behaviour:
- Reset values: config_addr=IDLE_ADDR, config_data=0, req_ready=0, req_done=0, busy=0, grant_id=NREQ-1 (so requester 0 has first priority), settle_timeout=0, state=IDLE.
- FSM states: IDLE, HOLD, SETTLE, GAP.
- IDLE:
  - The search starts at grant_id+1 (mod NREQ). The first requester found with req_valid=1 is selected.
  - req_ready is combinational: state==IDLE & selected & !a_rst.
  - The accept cycle is T. At the clock edge, latch addr/data, update grant_id, set an 8-bit hold counter.
  - If addr==IDLE_ADDR, go to GAP (no-op, no bus write). Otherwise go to HOLD.
- HOLD:
  - config_addr/config_data are registered and driven with the latched values during cycles T+1..T+HOLD_CYCLES.
  - Next state is SETTLE if addr==SETTLE_ADDR, else GAP.
- SETTLE:
  - config_addr=IDLE_ADDR; config_data keeps the latched value.
  - Compare the registered monitors against latched data[31:0], [63:32], [95:64] (exact equality).
  - Go to GAP on the first cycle all three match.
  - A 32-bit counter runs from entry. When it reaches TIMEOUT_CYCLES, set settle_timeout and go to GAP.
- GAP:
  - config_addr=IDLE_ADDR for GAP_CYCLES cycles, then go to IDLE.
  - The req_done bit of the granted requester pulses in the first IDLE cycle.
  - A new request may be accepted in that same cycle.
- Non-settle write latency: accept at T, done at T+HOLD_CYCLES+GAP_CYCLES+1 (T+7 at defaults).
- Dropping req_valid before acceptance cancels the request silently. req_valid/addr/data are ignored after acceptance.
- Only one request is in flight at a time. Requesters must not re-assert a new request until done (a re-asserted request is simply queued by round-robin).
- Reset mid-operation:
  - Next cycle is IDLE with config_addr=IDLE_ADDR.
  - No req_done is issued for the aborted request.
  - The round-robin pointer returns to its reset value.
- Monitor values are registered once (1-cycle latency) before comparison.

Test Plan:
- Single write: requester 1 sends addr=1101, data[63:0]={32'h10000000,32'h0} -> ready at T; config_addr=1101 for T+1..T+4; config_addr=0 at T+5, T+6; req_done[1] at T+7.
- Round-robin: all four valid continuously -> grant order 0,1,2,3,0; each done is followed by ready of the next requester in the same cycle.
- Settle success: addr=1100, x target=1000, monitor X0 ramps 32/step reaching 1000 at cycle S, with Y0/Z0 already matching -> done exactly GAP_CYCLES+2 cycles after S; settle_timeout=0.
- Settle timeout: TIMEOUT_CYCLES=50, monitors never match -> settle_timeout=1 after 50 SETTLE cycles; done still pulses; the next accepted 1100 write clears it.
- No-op and cancel: addr=0 request -> ready, no HOLD cycles, done at T+GAP_CYCLES+1. A request deasserted while another is in flight -> never granted.
- Reset mid-HOLD: assert a_rst at T+2 -> config_addr=0 next cycle, busy=0, no req_done, grant_id=NREQ-1.
